// File: rtl/pipe_alu.sv
// rtl/pipe_alu.sv - two-stage valid/ready ALU pipeline with sticky overflow (option: ALU_SAT_EN)
module pipe_alu #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             ovf_sticky,
  input  logic             clr_ovf
);

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_XOR  = 3'd3,
    OP_ADD  = 3'd4,
    OP_SUB  = 3'd5,
    OP_SLLI = 3'd6,
    OP_SRLI = 3'd7
  } op_t;

  localparam int MSB = WIDTH - 1;

`ifdef ALU_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  // Stage 1: captured operands
  logic             r_s1_valid;
  op_t              r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;

  // Stage 2: registered result, which is also the output beat
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_overflow;
  logic             r_sticky;

  logic             w_s2_ready;
  logic             w_s1_ready;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [SHW-1:0]   w_shamt;
  logic             w_shift_big;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;

  // Handshake: a stage may load when it is empty or the stage after it is moving
  assign w_s2_ready = !r_s2_valid || out_ready;
  assign w_s1_ready = !r_s1_valid || w_s2_ready;
  assign in_ready   = !reset && w_s1_ready;

  assign out_valid  = r_s2_valid;
  assign result     = r_result;
  assign overflow   = r_overflow;
  assign ovf_sticky = r_sticky;

  assign w_sum       = r_s1_a + r_s1_b;
  assign w_diff      = r_s1_a - r_s1_b;
  assign w_shamt     = r_s1_b[SHW-1:0];
  // The shift field can encode amounts past the operand width; those clear the result
  assign w_shift_big = ({{(32-SHW){1'b0}}, w_shamt} >= 32'(WIDTH));

  // Operation decode and signed-overflow detection on the stage-1 operands
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (r_s1_op)
      OP_AND:  w_res = r_s1_a & r_s1_b;
      OP_OR:   w_res = r_s1_a | r_s1_b;
      OP_XOR:  w_res = r_s1_a ^ r_s1_b;
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = (r_s1_a[MSB] == r_s1_b[MSB]) && (w_sum[MSB] != r_s1_a[MSB]);
      end
      OP_SUB: begin
        w_res = w_diff;
        w_ovf = (r_s1_a[MSB] != r_s1_b[MSB]) && (w_diff[MSB] != r_s1_a[MSB]);
      end
      OP_SLLI: w_res = w_shift_big ? '0 : (r_s1_a << w_shamt);
      OP_SRLI: w_res = w_shift_big ? '0 : (r_s1_a >> w_shamt);
      default: w_res = '0;
    endcase
`ifdef ALU_SAT_EN
    // On overflow the true result's sign matches operand A, so A picks the rail
    if (w_ovf) begin
      w_res = r_s1_a[MSB] ? SAT_MIN : SAT_MAX;
    end
`endif
  end

  // Stage 1 register: load a new beat (or a bubble) whenever stage 1 can advance
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= OP_NOP;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (w_s1_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_op <= op_t'(opcode);
        r_s1_a  <= in1;
        r_s1_b  <= in2;
      end
    end
  end

  // Stage 2 register: result/overflow only change when a real beat moves in
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_overflow <= 1'b0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result   <= w_res;
        r_overflow <= w_ovf;
      end
    end
  end

  // Sticky overflow: an overflowing output transfer wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sticky <= 1'b0;
    end else if (r_s2_valid && out_ready && r_overflow) begin
      r_sticky <= 1'b1;
    end else if (clr_ovf) begin
      r_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_alu.sv
// tb/tb_pipe_alu.sv - directed table-driven bench for pipe_alu
module tb_pipe_alu;

  localparam logic [2:0] NOP = 3'd0, AND = 3'd1, OR = 3'd2, XOR = 3'd3;
  localparam logic [2:0] ADD = 3'd4, SUB = 3'd5, SLLI = 3'd6, SRLI = 3'd7;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [2:0] opcode;
  logic [7:0] in1, in2, result;
  logic       overflow, ovf_sticky, clr_ovf;

  logic       v4, rdy4, ov4, or4, ovf4, stk4;
  logic [2:0] op4;
  logic [3:0] a4, b4, res4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_alu #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .in1(in1), .in2(in2), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .overflow(overflow),
    .ovf_sticky(ovf_sticky), .clr_ovf(clr_ovf)
  );

  pipe_alu #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(v4), .in_ready(rdy4),
    .opcode(op4), .in1(a4), .in2(b4), .out_valid(ov4),
    .out_ready(or4), .result(res4), .overflow(ovf4),
    .ovf_sticky(stk4), .clr_ovf(1'b0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res_wrap;
    logic [7:0] res_sat;
    logic       ovf;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic       sticky_model;
    logic [7:0] exp_res;
    logic [7:0] stall_exp[2];
    int         lat, accepted, n, stale;
    bit         found;

    vecs[0]  = '{AND,  8'hF0, 8'h3C, 8'h30, 8'h30, 1'b0};
    vecs[1]  = '{OR,   8'hF0, 8'h0C, 8'hFC, 8'hFC, 1'b0};
    vecs[2]  = '{XOR,  8'hFF, 8'h0F, 8'hF0, 8'hF0, 1'b0};
    vecs[3]  = '{ADD,  8'h10, 8'h20, 8'h30, 8'h30, 1'b0};
    vecs[4]  = '{NOP,  8'h55, 8'hAA, 8'h00, 8'h00, 1'b0};
    vecs[5]  = '{SUB,  8'h05, 8'h03, 8'h02, 8'h02, 1'b0};
    vecs[6]  = '{SLLI, 8'h81, 8'h03, 8'h08, 8'h08, 1'b0};
    vecs[7]  = '{SRLI, 8'h81, 8'h08, 8'h00, 8'h00, 1'b0};
    vecs[8]  = '{SRLI, 8'h81, 8'h07, 8'h01, 8'h01, 1'b0};
    vecs[9]  = '{SLLI, 8'h81, 8'h13, 8'h08, 8'h08, 1'b0};
    vecs[10] = '{ADD,  8'h7F, 8'h01, 8'h80, 8'h7F, 1'b1};
    vecs[11] = '{ADD,  8'h80, 8'hFF, 8'h7F, 8'h80, 1'b1};
    vecs[12] = '{SUB,  8'h80, 8'h01, 8'h7F, 8'h80, 1'b1};
    vecs[13] = '{SUB,  8'h7F, 8'hFF, 8'h80, 8'h7F, 1'b1};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; opcode = NOP;
    in1 = '0; in2 = '0; clr_ovf = 1'b0;
    v4 = 1'b0; or4 = 1'b1; op4 = NOP; a4 = '0; b4 = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_sticky", 32'(ovf_sticky), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Table vectors, one beat at a time
    sticky_model = 1'b0;
    foreach (vecs[i]) begin
`ifdef ALU_SAT_EN
      exp_res = vecs[i].res_sat;
`else
      exp_res = vecs[i].res_wrap;
`endif
      in_valid = 1'b1; opcode = vecs[i].op; in1 = vecs[i].a; in2 = vecs[i].b;
      found = 1'b0; lat = 0;
      for (int c = 1; c <= 5 && !found; c++) begin
        @(negedge clk);
        if (c == 1) begin
          in_valid = 1'b0; opcode = 3'($urandom); in1 = 8'($urandom); in2 = 8'($urandom);
        end
        if (out_valid) begin
          found = 1'b1;
          lat = c;
        end
      end
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
      chk($sformatf("v%0d_result", i), 32'(result), 32'(exp_res));
      chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].ovf));
      @(negedge clk);
      sticky_model = sticky_model | vecs[i].ovf;
      chk($sformatf("v%0d_sticky", i), 32'(ovf_sticky), 32'(sticky_model));
    end

    // Back-to-back: one result per cycle, two cycles after each accept
    for (int j = 0; j < 10; j++) begin
      chk($sformatf("b2b_valid_%0d", j), 32'(out_valid), 32'(j >= 2 && j < 8));
      if (j >= 2 && j < 8)
        chk($sformatf("b2b_result_%0d", j), 32'(result), 32'(j));
      if (j < 6) begin
        chk($sformatf("b2b_in_ready_%0d", j), 32'(in_ready), 32'd1);
        in_valid = 1'b1; opcode = ADD; in1 = 8'(j + 1); in2 = 8'd1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end

    // Output stall for 5 cycles: two beats fill the pipe, then in_ready drops
    stall_exp[0] = 8'h11; stall_exp[1] = 8'h21;
    out_ready = 1'b0; accepted = 0;
    for (int j = 0; j < 7; j++) begin
      if (j >= 2) begin
        chk($sformatf("stall_in_ready_%0d", j), 32'(in_ready), 32'd0);
        chk($sformatf("stall_hold_%0d", j), {23'd0, out_valid, result}, {23'd0, 1'b1, 8'h11});
      end
      in_valid = 1'b1; opcode = ADD; in1 = 8'(8'h10 * (accepted + 1)); in2 = 8'd1;
      if (in_ready) accepted++;
      @(negedge clk);
    end
    chk("stall_accepted", 32'(accepted), 32'd2);
    in_valid = 1'b0; out_ready = 1'b1; n = 0;
    for (int t = 0; t < 4; t++) begin
      if (out_valid) begin
        if (n < 2) chk($sformatf("stall_order_%0d", n), 32'(result), 32'(stall_exp[n]));
        n++;
      end
      @(negedge clk);
    end
    chk("stall_drained", 32'(n), 32'd2);

    // Sticky: clear alone, then clear racing an overflowing transfer
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("clr_alone", 32'(ovf_sticky), 32'd0);
    in_valid = 1'b1; opcode = ADD; in1 = 8'h7F; in2 = 8'h01;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("race_out_valid", 32'(out_valid), 32'd1);
    clr_ovf = 1'b1;
    @(negedge clk);
    chk("race_set_wins", 32'(ovf_sticky), 32'd1);
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("race_clear_next", 32'(ovf_sticky), 32'd0);

    // WIDTH=4 ADD overflow
    v4 = 1'b1; op4 = ADD; a4 = 4'd7; b4 = 4'd1;
    @(negedge clk);
    v4 = 1'b0;
    @(negedge clk);
    chk("w4_valid", 32'(ov4), 32'd1);
`ifdef ALU_SAT_EN
    chk("w4_result", 32'(res4), 32'h7);
`else
    chk("w4_result", 32'(res4), 32'h8);
`endif
    chk("w4_overflow", 32'(ovf4), 32'd1);
    @(negedge clk);
    chk("w4_sticky", 32'(stk4), 32'd1);

    // Reset with two beats in flight
    in_valid = 1'b1; opcode = XOR; in1 = 8'hA5; in2 = 8'h0F;
    @(negedge clk);
    in1 = 8'h5A;
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready_after", 32'(in_ready), 32'd1);
    stale = 0;
    for (int t = 0; t < 4; t++) begin
      if (out_valid) stale++;
      @(negedge clk);
    end
    chk("midrst_no_stale", 32'(stale), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
